// File: rtl/amm_ram_responder_if.sv
// Avalon-MM style memory bus between an initiator (master) and amm_ram_responder (slave).
interface amm_ram_responder_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned BYTE_CNT   = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [BYTE_CNT-1:0]   byteenable;
   logic                  waitrequest;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  datavalid;
   logic                  illegal;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, datavalid, illegal
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, datavalid, illegal
   );
endinterface

// File: rtl/amm_ram_responder.sv
// Word-addressed RAM responder with byte enables, pipelined reads and registered back-pressure.
// Optional macro AMM_RESP_RANDOM_WAIT_EN adds LFSR-driven random waitrequest insertion.
module amm_ram_responder #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned BYTE_CNT     = DATA_WIDTH / 8,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned WAIT_CYCLES  = 0
) (
   input logic              clk,
   input logic              rst_n,
   amm_ram_responder_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [3:0]              wait_cnt;
   logic [3:0]              wait_cnt_nxt;
   logic                    wait_q;
   logic                    illegal_q;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    force_wait;
   logic [READ_LATENCY-1:0] vld;
   logic [DATA_WIDTH-1:0]   dat [READ_LATENCY];

   // A simultaneous read+write is taken as a write only.
   always_comb begin
      wr_acc = bus.write & ~wait_q;
      rd_acc = bus.read & ~bus.write & ~wait_q;
      wait_cnt_nxt = '0;
      if (wr_acc || rd_acc)
         wait_cnt_nxt = 4'(WAIT_CYCLES);
      else if (wait_cnt != 4'd0)
         wait_cnt_nxt = wait_cnt - 4'd1;
   end

`ifdef AMM_RESP_RANDOM_WAIT_EN
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   // waitrequest is registered, so look at the value the LFSR takes in the coming cycle.
   always_comb begin
      lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      force_wait = (lfsr_nxt[1:0] == 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= 16'hACE1;
      else
         lfsr <= lfsr_nxt;
   end
`else
   always_comb force_wait = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         wait_q    <= 1'b1;
         illegal_q <= 1'b0;
         vld       <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            dat[i] <= '0;
      end else begin
         wait_cnt  <= wait_cnt_nxt;
         wait_q    <= (wait_cnt_nxt != 4'd0) | force_wait;
         illegal_q <= wr_acc & bus.read;
         // Invalid stages carry zero data so readdata is 0 whenever datavalid is 0.
         vld[0]    <= rd_acc;
         dat[0]    <= rd_acc ? mem[bus.address] : '0;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int unsigned i = 0; i < BYTE_CNT; i++)
            if (bus.byteenable[i])
               mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
   end

   assign bus.waitrequest = wait_q;
   assign bus.illegal     = illegal_q;
   assign bus.datavalid   = vld[READ_LATENCY-1];
   assign bus.readdata    = dat[READ_LATENCY-1];
endmodule

// File: tb/tb_amm_ram_responder.sv
// Scoreboard bench: DUT 0 (latency 3, no wait) and DUT 1 (latency 2, 3 wait cycles).
module tb_amm_ram_responder;
   typedef struct {
      int          due;
      logic [63:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   w;
   int   ill_due [2];
   rsp_t q0[$];
   rsp_t q1[$];
   logic [63:0] mdl [2][1024];

   logic        rd_s [2];
   logic        wr_s [2];
   logic [9:0]  ad_s [2];
   logic [63:0] wd_s [2];
   logic [7:0]  be_s [2];

   amm_ram_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .BYTE_CNT(8)) m0 ();
   amm_ram_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .BYTE_CNT(8)) m1 ();

   assign m0.read = rd_s[0];  assign m0.write = wr_s[0];  assign m0.address = ad_s[0];
   assign m0.writedata = wd_s[0];  assign m0.byteenable = be_s[0];
   assign m1.read = rd_s[1];  assign m1.write = wr_s[1];  assign m1.address = ad_s[1];
   assign m1.writedata = wd_s[1];  assign m1.byteenable = be_s[1];

   amm_ram_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .BYTE_CNT(8),
                       .READ_LATENCY(3), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));
   amm_ram_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .BYTE_CNT(8),
                       .READ_LATENCY(2), .WAIT_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic wreq(input int d);
      return (d == 0) ? m0.waitrequest : m1.waitrequest;
   endfunction

   function automatic int lat(input int d);
      return (d == 0) ? 3 : 2;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic cmd(input int d, input logic rd, input logic wr, input logic [9:0] a,
                      input logic [63:0] wdat, input logic [7:0] be, output int waits);
      rsp_t r;
      rd_s[d] = rd; wr_s[d] = wr; ad_s[d] = a; wd_s[d] = wdat; be_s[d] = be;
      waits = 0;
      forever begin
         @(negedge clk);
         if (!wreq(d) || waits > 40) break;
         waits++;
      end
      chk("accept", wreq(d), 1'b0);
      if (wr)
         for (int i = 0; i < 8; i++)
            if (be[i]) mdl[d][a][8*i +: 8] = wdat[8*i +: 8];
      if (rd && !wr) begin
         r.due = cyc + lat(d);
         r.data = mdl[d][a];
         if (d == 0) q0.push_back(r); else q1.push_back(r);
      end
      if (rd && wr) ill_due[d] = cyc + 1;
      @(posedge clk); #1;
      rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      ad_s[d] = 10'($urandom); wd_s[d] = {$urandom, $urandom}; be_s[d] = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mon(input int d, input logic dv, input logic [63:0] rdat, input logic ill);
      logic exp_dv;
      rsp_t r;
      exp_dv = 1'b0;
      if (d == 0) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin exp_dv = 1'b1; r = q0.pop_front(); end
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin exp_dv = 1'b1; r = q1.pop_front(); end
      end
      chk($sformatf("datavalid%0d", d), dv, exp_dv);
      if (exp_dv) chk($sformatf("readdata%0d", d), rdat, r.data);
      else        chk($sformatf("readdata_idle%0d", d), rdat, '0);
      chk($sformatf("illegal%0d", d), ill, cyc == ill_due[d]);
   endtask

   always @(negedge clk) begin
      mon(0, m0.datavalid, m0.readdata, m0.illegal);
      mon(1, m1.datavalid, m1.readdata, m1.illegal);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ill_due[0] = -10; ill_due[1] = -10;
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b0; wr_s[d] = 1'b0; ad_s[d] = '0; wd_s[d] = '0; be_s[d] = '0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_wait0", m0.waitrequest, 1'b1);
      chk("rst_wait1", m1.waitrequest, 1'b1);
      @(negedge clk); #2 rst_n = 1'b1;
      chk("rel_wait0", m0.waitrequest, 1'b1);
      @(posedge clk); #1;
      chk("post_rel_wait0", m0.waitrequest, 1'b0);

      // Full write then read, then partial write followed immediately by a read
      cmd(0, 1'b0, 1'b1, 10'd5, 64'h1122334455667788, 8'hFF, w);
      cmd(0, 1'b1, 1'b0, 10'd5, '0, '0, w);
      idle(5);
      cmd(0, 1'b0, 1'b1, 10'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F, w);
      cmd(0, 1'b1, 1'b0, 10'd5, '0, '0, w);
      idle(5);

      // Back-to-back reads of 0..7
      for (int i = 0; i < 8; i++) cmd(0, 1'b0, 1'b1, 10'(i), {$urandom, $urandom}, 8'hFF, w);
      for (int i = 0; i < 8; i++) begin
         cmd(0, 1'b1, 1'b0, 10'(i), '0, '0, w);
         chk("b2b_waits", w, 0);
      end
      idle(6);

      // Read and write together: write-only, illegal pulse, no response
      cmd(0, 1'b0, 1'b1, 10'd9, 64'h0, 8'hFF, w);
      cmd(0, 1'b1, 1'b1, 10'd9, 64'hA5, 8'h01, w);
      idle(6);
      cmd(0, 1'b1, 1'b0, 10'd9, '0, '0, w);
      idle(5);

      // Random mix over initialised addresses
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0)
            cmd(0, 1'b0, 1'b1, 10'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom), w);
         else
            cmd(0, 1'b1, 1'b0, 10'($urandom_range(0, 7)), '0, '0, w);
      end
      idle(6);

      // DUT 1: three forced wait cycles after every accepted command
      cmd(1, 1'b0, 1'b1, 10'd3, 64'hCAFEF00D12345678, 8'hFF, w);
      chk("wait_first", w, 0);
      cmd(1, 1'b1, 1'b0, 10'd3, '0, '0, w);
      chk("wait_read", w, 3);
      cmd(1, 1'b0, 1'b1, 10'd3, 64'h0, 8'h00, w);
      chk("wait_be0", w, 3);
      cmd(1, 1'b1, 1'b0, 10'd3, '0, '0, w);
      chk("wait_read2", w, 3);
      cmd(1, 1'b0, 1'b1, 10'd3, 64'h0, 8'hF0, w);
      chk("wait_wr", w, 3);
      cmd(1, 1'b1, 1'b0, 10'd3, '0, '0, w);
      chk("wait_read3", w, 3);
      idle(8);

      // Reset with two reads outstanding on DUT 0
      cmd(0, 1'b1, 1'b0, 10'd0, '0, '0, w);
      cmd(0, 1'b1, 1'b0, 10'd1, '0, '0, w);
      rst_n = 1'b0;
      q0.delete(); q1.delete();
      #1;
      chk("mid_rst_wait0", m0.waitrequest, 1'b1);
      chk("mid_rst_wait1", m1.waitrequest, 1'b1);
      chk("mid_rst_dv0", m0.datavalid, 1'b0);
      chk("mid_rst_rd0", m0.readdata, '0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      chk("rel2_wait0", m0.waitrequest, 1'b1);
      @(posedge clk); #1;
      chk("post_rel2_wait0", m0.waitrequest, 1'b0);
      chk("post_rel2_wait1", m1.waitrequest, 1'b0);
      idle(6);

      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
